// File: rtl/serial_accumulator.sv
// Serial accumulator: sums a start-specified number of streamed operands and
// returns the wrapped sum plus a sticky carry-out flag through a valid/ready port.

module ripple_carry_adder #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum
);

  // The final carry is dropped; callers detect wrap by comparing the sum.
  always_comb begin : ripple
    logic carry;
    carry = 1'b0;
    sum   = '0;
    for (int i = 0; i < WIDTH; i++) begin
      sum[i] = a[i] ^ b[i] ^ carry;
      carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
  end

endmodule

// state | meaning
// IDLE  | waiting for start; last result held on out_sum/out_overflow
// ACCUM | accepting operands until the remaining count reaches zero
// DONE  | result presented, waiting for out_ready
module serial_accumulator #(
  parameter int BUS_WIDTH   = 32,
  parameter int COUNT_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [COUNT_WIDTH-1:0] len,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [BUS_WIDTH-1:0]   in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [BUS_WIDTH-1:0]   out_sum,
  output logic                   out_overflow,
  output logic                   busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [BUS_WIDTH-1:0]   acc_q, acc_d;
  logic                   ovf_q, ovf_d;
  logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [BUS_WIDTH-1:0]   add_sum;

  ripple_carry_adder #(.WIDTH(BUS_WIDTH)) u_adder (
    .a   (acc_q),
    .b   (in_data),
    .sum (add_sum)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          acc_d = '0;
          ovf_d = 1'b0;
          cnt_d = len;
          state_d = (len != '0) ? ACCUM : DONE;
        end
      end
      ACCUM: begin
        if (in_valid) begin
          acc_d = add_sum;
          // A wrapped unsigned sum is smaller than the value it started from.
          ovf_d = ovf_q | (add_sum < acc_q);
          cnt_d = cnt_q - COUNT_WIDTH'(1);
          if (cnt_q == COUNT_WIDTH'(1)) state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready     = (state_q == ACCUM);
    out_valid    = (state_q == DONE);
    busy         = (state_q != IDLE);
    out_sum      = acc_q;
    out_overflow = ovf_q;
  end

endmodule

// File: tb/tb_serial_accumulator.sv
// Bench for serial_accumulator: directed vector table, corner sequences and
// randomized transactions checked against an arithmetic reference model.

module tb_serial_accumulator;

  localparam int BW = 32;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [CW-1:0] len = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [BW-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [BW-1:0] out_sum;
  logic          out_overflow;
  logic          busy;

  int checks = 0;
  int errors = 0;
  logic [BW-1:0] beats [256];

  typedef struct {
    int                  n;
    logic [3:0][BW-1:0]  b;
    logic [BW-1:0]       sum;
    bit                  ovf;
  } vec_t;

  vec_t vecs [6];

  serial_accumulator #(.BUS_WIDTH(BW), .COUNT_WIDTH(CW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .len          (len),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_sum      (out_sum),
    .out_overflow (out_overflow),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain wide arithmetic, flag any addition that reaches 2^32.
  function automatic void model(input int n, output logic [BW-1:0] s, output bit o);
    longint unsigned acc;
    acc = 0;
    o = 1'b0;
    for (int i = 0; i < n; i++) begin
      acc = acc + longint'(beats[i]);
      if (acc >= 64'h1_0000_0000) begin
        o = 1'b1;
        acc = acc - 64'h1_0000_0000;
      end
    end
    s = acc[BW-1:0];
  endfunction

  task automatic run_txn(input int n, input int gap_pct, input int stall, input bit poke,
                         input logic [BW-1:0] es, input bit eo, input string tag);
    int idx;
    int cyc;
    logic [BW-1:0] held;
    @(negedge clk);
    chk({tag, "_idle_busy"}, 64'(busy), 64'd0);
    start = 1'b1;
    len = n[CW-1:0];
    @(negedge clk);
    start = 1'b0;
    idx = 0;
    cyc = 0;
    while (idx < n && cyc < 4000) begin
      chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
      chk({tag, "_early_valid"}, 64'(out_valid), 64'd0);
      in_valid = ($urandom_range(0, 99) >= gap_pct);
      in_data = beats[idx];
      start = poke & ($urandom_range(0, 1) == 1);
      len = 8'd3;
      @(negedge clk);
      if (in_valid) idx++;
      cyc++;
    end
    in_valid = 1'b0;
    in_data = '0;
    start = 1'b0;
    if (cyc >= 4000) chk({tag, "_beat_timeout"}, 64'd1, 64'd0);
    chk({tag, "_out_valid"}, 64'(out_valid), 64'd1);
    chk({tag, "_done_in_ready"}, 64'(in_ready), 64'd0);
    chk({tag, "_done_busy"}, 64'(busy), 64'd1);
    chk({tag, "_sum"}, 64'(out_sum), 64'(es));
    chk({tag, "_ovf"}, 64'(out_overflow), 64'(eo));
    held = out_sum;
    repeat (stall) begin
      out_ready = 1'b0;
      start = poke;
      @(negedge clk);
      chk({tag, "_stall_valid"}, 64'(out_valid), 64'd1);
      chk({tag, "_stall_sum"}, 64'(out_sum), 64'(held));
    end
    out_ready = 1'b1;
    start = poke;
    len = 8'd5;
    @(negedge clk);
    out_ready = 1'b0;
    start = 1'b0;
    chk({tag, "_ret_busy"}, 64'(busy), 64'd0);
    chk({tag, "_ret_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_retain_sum"}, 64'(out_sum), 64'(es));
    chk({tag, "_retain_ovf"}, 64'(out_overflow), 64'(eo));
  endtask

  initial begin
    logic [BW-1:0] ms;
    bit mo;

    vecs[0].n = 3; vecs[0].b = {32'd0, 32'd9, 32'd7, 32'd5};
    vecs[0].sum = 32'd21; vecs[0].ovf = 1'b0;
    vecs[1].n = 2; vecs[1].b = {32'd0, 32'd0, 32'h2, 32'hFFFF_FFFF};
    vecs[1].sum = 32'h1; vecs[1].ovf = 1'b1;
    vecs[2].n = 0; vecs[2].b = '0;
    vecs[2].sum = 32'h0; vecs[2].ovf = 1'b0;
    vecs[3].n = 4; vecs[3].b = {32'd4, 32'd3, 32'd2, 32'd1};
    vecs[3].sum = 32'd10; vecs[3].ovf = 1'b0;
    vecs[4].n = 3; vecs[4].b = {32'd0, 32'h0, 32'h7FFF_FFFF, 32'h8000_0000};
    vecs[4].sum = 32'hFFFF_FFFF; vecs[4].ovf = 1'b0;
    vecs[5].n = 3; vecs[5].b = {32'd0, 32'd5, 32'd1, 32'hFFFF_FFFF};
    vecs[5].sum = 32'd5; vecs[5].ovf = 1'b1;

    #2;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_sum", 64'(out_sum), 64'd0);
    chk("rst_ovf", 64'(out_overflow), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int v = 0; v < 6; v++) begin
      for (int i = 0; i < 4; i++) beats[i] = vecs[v].b[i];
      run_txn(vecs[v].n, 0, 0, 1'b0, vecs[v].sum, vecs[v].ovf, $sformatf("vec%0d", v));
    end

    // Backpressure: random input gaps and a 5-cycle output stall.
    for (int i = 0; i < 4; i++) beats[i] = $urandom;
    model(4, ms, mo);
    run_txn(4, 50, 5, 1'b0, ms, mo, "bp");

    // Start pulses during ACCUM and on the handshake must be ignored.
    beats[0] = 32'd100; beats[1] = 32'd200; beats[2] = 32'd300;
    run_txn(3, 30, 2, 1'b1, 32'd600, 1'b0, "ign");

    // Maximum length, no count wrap.
    for (int i = 0; i < 255; i++) beats[i] = $urandom;
    model(255, ms, mo);
    run_txn(255, 10, 1, 1'b0, ms, mo, "maxlen");

    for (int t = 0; t < 12; t++) begin
      int n;
      n = $urandom_range(0, 12);
      for (int i = 0; i < n; i++)
        beats[i] = ($urandom_range(0, 1) == 1) ? (32'hFFFF_FF00 | 32'($urandom_range(0, 255))) : $urandom;
      model(n, ms, mo);
      run_txn(n, $urandom_range(0, 60), $urandom_range(0, 3), 1'(t % 2), ms, mo, $sformatf("rnd%0d", t));
    end

    // Reset after 2 of 4 beats discards the partial result.
    @(negedge clk);
    start = 1'b1;
    len = 8'd4;
    @(negedge clk);
    start = 1'b0;
    in_valid = 1'b1;
    in_data = 32'd77;
    repeat (2) @(negedge clk);
    in_valid = 1'b0;
    chk("pre_rst_busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_in_ready", 64'(in_ready), 64'd0);
    chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_sum", 64'(out_sum), 64'd0);
    chk("mid_rst_ovf", 64'(out_overflow), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    beats[0] = 32'd10;
    run_txn(1, 0, 0, 1'b0, 32'd10, 1'b0, "post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_accumulator.md
SERIAL_ACCUMULATOR -- requirements
Module: serial_accumulator

Interface
REQ-001 The module SHALL have parameter BUS_WIDTH, default 32, giving the operand and sum width in bits.
REQ-002 The module SHALL have parameter COUNT_WIDTH, default 8, giving the width of the beat-count field.
REQ-003 The module SHALL have one clock and one reset: the clock is clk and the reset is rst_n; rst_n is asynchronous and active-low.
REQ-004 Ports SHALL be, in order:
- clk  input  1  clock; all state changes on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begin a new accumulation; sampled only in IDLE.
- len  input  COUNT_WIDTH  number of operands to sum; sampled with start.
- in_valid  input  1  in_data holds a valid operand.
- in_ready  output  1  block accepts an operand this cycle.
- in_data  input  BUS_WIDTH  unsigned operand.
- out_valid  output  1  out_sum and out_overflow are valid.
- out_ready  input  1  consumer accepts the result.
- out_sum  output  BUS_WIDTH  accumulated sum modulo 2^BUS_WIDTH.
- out_overflow  output  1  at least one addition produced a carry out of bit BUS_WIDTH-1.
- busy  output  1  block is not in IDLE.

Function
REQ-005 The block SHALL implement a three-state FSM: IDLE, ACCUM, DONE.
REQ-006 IDLE outputs: in_ready=0, out_valid=0, busy=0.
REQ-007 In IDLE, start=1 with len!=0 SHALL clear the accumulator and overflow flag, load the remaining count with len, and move to ACCUM on the next edge.
REQ-008 In IDLE, start=1 with len=0 SHALL clear the accumulator and overflow flag and move directly to DONE; the result is out_sum=0, out_overflow=0.
REQ-009 start SHALL be ignored in ACCUM and DONE, including when it coincides with the final input beat or with the output handshake.
REQ-010 ACCUM outputs: in_ready=1, out_valid=0, busy=1.
REQ-011 An input beat SHALL be accepted only on a rising edge where in_valid=1 and in_ready=1.
REQ-012 On each accepted beat:
- the accumulator becomes (accumulator + in_data) mod 2^BUS_WIDTH;
- out_overflow is set if the unsigned addition carries out of bit BUS_WIDTH-1;
- the remaining count decrements by one.
REQ-013 The addition SHALL be performed by a ripple_carry_adder instance of width BUS_WIDTH.
REQ-014 The carry out SHALL be detected as (new sum < old accumulator), unsigned compare.
REQ-015 out_overflow SHALL be sticky and SHALL NOT clear within an accumulation.
REQ-016 When the accepted beat is the one that brings the remaining count to zero, the FSM SHALL move to DONE on that edge; out_valid asserts in the following cycle, one cycle of latency after the last beat.
REQ-017 In ACCUM, in_valid=0 cycles SHALL leave all state unchanged; there is no timeout.
REQ-018 DONE outputs: out_valid=1, in_ready=0, busy=1.
REQ-019 In DONE, out_sum and out_overflow SHALL hold stable until the handshake.
REQ-020 In DONE, out_valid=1 with out_ready=1 on a rising edge SHALL complete the output handshake and return the FSM to IDLE.
REQ-021 out_valid SHALL NOT depend combinationally on out_ready.
REQ-022 out_sum and out_overflow SHALL retain the last result after returning to IDLE, until the next accepted start clears them.
REQ-023 len = 2^COUNT_WIDTH-1 SHALL be supported, with no count wrap.
REQ-024 The accumulator SHALL wrap modulo 2^BUS_WIDTH with no saturation.
REQ-025 in_ready and out_valid SHALL be driven from registered state only, with no combinational input-to-output path.

Reset
REQ-026 While rst_n=0, the block SHALL immediately (asynchronously) force: FSM=IDLE, accumulator=0, remaining count=0, out_sum=0, out_overflow=0, in_ready=0, out_valid=0, busy=0.
REQ-027 Reset asserted mid-ACCUM or mid-DONE SHALL abort the operation; any partial or pending result is discarded.
REQ-028 After rst_n deasserts, the first possible accepted start is on the first rising edge with rst_n=1.

Verification
REQ-029 Basic sum: BUS_WIDTH=32; start, len=3; beats 5, 7, 9 with in_valid held high -> out_valid one cycle after the third beat, out_sum=21, out_overflow=0.
REQ-030 Wrap and overflow: len=2; beats 0xFFFFFFFF, 0x00000002 -> out_sum=0x00000001, out_overflow=1.
REQ-031 Zero length: start, len=0 -> DONE on the next cycle, out_sum=0, out_overflow=0, in_ready never asserts.
REQ-032 Backpressure and gaps:
- len=4; in_valid toggled randomly, out_ready held low 5 cycles in DONE -> beats counted only on in_valid&in_ready;
- out_sum is stable across the stall;
- return to IDLE on the first edge with out_ready=1.
REQ-033 Ignored start: start pulsed during ACCUM and on the DONE handshake cycle -> no change to count, sum, or state.
REQ-034 Reset mid-operation: rst_n pulsed low after 2 of 4 beats -> all outputs 0 immediately; a new start with len=1 and beat 10 -> out_sum=10, out_overflow=0.
